// File: rtl/mux_stream_nt1_if.sv
// Stream bundle for mux_stream_nt1: N producer channels in, one registered channel out.
// master = producer/consumer side, slave = the multiplexer.
interface mux_stream_nt1_if #(
   parameter int WIDTH = 64,
   parameter int N     = 4,
   parameter int SEL_W = 2
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [SEL_W-1:0]   sel;
   logic               rr_mode;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SEL_W-1:0]   out_src;

   modport master (
      output in_data, in_valid, sel, rr_mode, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );

   modport slave (
      input  in_data, in_valid, sel, rr_mode, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/mux_stream_nt1.sv
// N:1 valid/ready stream mux feeding one registered output stage (1 word/cycle).
// Define MUXN_RR_EN to add round-robin arbitration selected by rr_mode; default is fixed sel.
module mux_stream_nt1 #(
   parameter int WIDTH = 64,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   mux_stream_nt1_if.slave bus
);
   logic             space;
   logic             granted;
   logic [SEL_W-1:0] grant;
   logic [N-1:0]     ready_vec;
   logic             xfer;
   logic [WIDTH-1:0] pick_data;

   assign space = !bus.out_valid || bus.out_ready;

`ifdef MUXN_RR_EN
   logic [SEL_W-1:0] ptr;
   logic             rr_hit;
   logic [SEL_W-1:0] rr_grant;

   // Scan starts just after the last granted channel so every requester gets a turn.
   always_comb begin
      rr_hit   = 1'b0;
      rr_grant = '0;
      for (int k = 1; k <= N; k++) begin
         if (!rr_hit && bus.in_valid[(int'(ptr) + k) % N]) begin
            rr_hit   = 1'b1;
            rr_grant = SEL_W'((int'(ptr) + k) % N);
         end
      end
   end

   always_comb begin
      if (bus.rr_mode) begin
         grant   = rr_grant;
         granted = rr_hit;
      end else begin
         grant   = bus.sel;
         granted = int'(bus.sel) < N;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= SEL_W'(N - 1);
      end else if (xfer && bus.rr_mode) begin
         ptr <= grant;
      end
   end
`else
   logic unused_rr_mode;
   assign unused_rr_mode = bus.rr_mode;
   assign grant          = bus.sel;
   assign granted        = int'(bus.sel) < N;
`endif

   always_comb begin
      ready_vec = '0;
      pick_data = '0;
      for (int i = 0; i < N; i++) begin
         ready_vec[i] = rst_n && space && granted && (int'(grant) == i);
         if (ready_vec[i]) begin
            pick_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.in_ready = ready_vec;
   assign xfer         = |(ready_vec & bus.in_valid);

   // A load wins over a drain, so a consumed word is replaced in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_src   <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= pick_data;
         bus.out_src   <= grant;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mux_stream_nt1.sv
// Bench for mux_stream_nt1: table-driven fixed-mode vectors with a data scoreboard,
// plus hand sequences for N=3 out-of-range select, reset mid-stall and round-robin (MUXN_RR_EN).
module tb_mux_stream_nt1;
   localparam int W = 64;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] iv;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_vld;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_stream_nt1_if #(.WIDTH(W), .N(4), .SEL_W(2)) bus4 ();
   mux_stream_nt1_if #(.WIDTH(W), .N(3), .SEL_W(2)) bus3 ();

   mux_stream_nt1 #(.WIDTH(W), .N(4), .SEL_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   mux_stream_nt1 #(.WIDTH(W), .N(3), .SEL_W(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   int          checks = 0;
   int          passes = 0;
   int          tag    = 0;
   logic        prev_vld = 1'b0;
   logic [W+1:0] sb[$];
   vec_t        vecs[15];

   function automatic logic [W-1:0] word(input int ch, input int n);
      return {32'hDEAD_BEEF, 24'(n), 8'(ch)};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step4(input logic [1:0] sel, input logic [3:0] iv, input logic ordy,
                        input logic rr, input logic [3:0] exp_rdy, input logic exp_vld,
                        input string name);
      logic [4*W-1:0] d;
      logic [W+1:0]   front;
      for (int i = 0; i < 4; i++) d[i*W +: W] = word(i, tag);
      bus4.in_data   = d;
      bus4.in_valid  = iv;
      bus4.sel       = sel;
      bus4.out_ready = ordy;
      bus4.rr_mode   = rr;
      #1;
      check($sformatf("%s in_ready", name), W'(bus4.in_ready), W'(exp_rdy));
      if (prev_vld && ordy && sb.size() > 0) void'(sb.pop_front());
      for (int i = 0; i < 4; i++)
         if (exp_rdy[i] && iv[i]) sb.push_back({2'(i), word(i, tag)});
      tag++;
      @(posedge clk); #1;
      check($sformatf("%s out_valid", name), W'(bus4.out_valid), W'(exp_vld));
      if (exp_vld) begin
         if (sb.size() == 0) begin
            check($sformatf("%s scoreboard_empty", name), W'(1), W'(0));
         end else begin
            front = sb[0];
            check($sformatf("%s out_data", name), bus4.out_data, front[W-1:0]);
            check($sformatf("%s out_src", name), W'(bus4.out_src), W'(front[W+1:W]));
         end
      end
      prev_vld = exp_vld;
   endtask

   task automatic do_reset(input int n);
      rst_n          = 1'b0;
      bus4.in_valid  = '1;
      bus4.out_ready = 1'b1;
      bus4.sel       = 2'd2;
      bus4.rr_mode   = 1'b0;
      bus3.in_valid  = '1;
      bus3.out_ready = 1'b1;
      bus3.sel       = 2'd2;
      bus3.rr_mode   = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
      check("rst in_ready4", W'(bus4.in_ready), W'(0));
      check("rst in_ready3", W'(bus3.in_ready), W'(0));
      check("rst out_valid", W'(bus4.out_valid), W'(0));
      check("rst out_data", bus4.out_data, W'(0));
      check("rst out_src", W'(bus4.out_src), W'(0));
      rst_n         = 1'b1;
      bus4.in_valid = '0;
      bus3.in_valid = '0;
      sb.delete();
      prev_vld = 1'b0;
   endtask

   initial begin
      //            sel    iv       ordy  exp_rdy  exp_vld
      vecs[0]  = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1};
      vecs[1]  = '{2'd2, 4'b0000, 1'b1, 4'b0100, 1'b0};
      vecs[2]  = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1};
      vecs[3]  = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1};
      vecs[4]  = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1};
      vecs[5]  = '{2'd3, 4'b1010, 1'b0, 4'b0000, 1'b1};
      vecs[6]  = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1};
      vecs[7]  = '{2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1};
      vecs[8]  = '{2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1};
      vecs[9]  = '{2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1};
      vecs[10] = '{2'd3, 4'b0111, 1'b1, 4'b1000, 1'b0};
      vecs[11] = '{2'd0, 4'b0000, 1'b0, 4'b0001, 1'b0};
      vecs[12] = '{2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1};
      vecs[13] = '{2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1};
      vecs[14] = '{2'd0, 4'b0000, 1'b1, 4'b0001, 1'b0};

      bus4.in_data = '0;
      bus3.in_data = '0;
      do_reset(2);

      for (int v = 0; v < 15; v++)
         step4(vecs[v].sel, vecs[v].iv, vecs[v].ordy, 1'b0,
               vecs[v].exp_rdy, vecs[v].exp_vld, $sformatf("vec%0d", v));

      // N=3 instance: sel=3 is out of range, so nothing is granted and the stage drains.
      for (int i = 0; i < 3; i++) bus3.in_data[i*W +: W] = word(i, 100);
      bus3.in_valid  = 3'b111;
      bus3.sel       = 2'd2;
      bus3.out_ready = 1'b1;
      #1;
      check("n3 in_ready sel2", W'(bus3.in_ready), W'(3'b100));
      @(posedge clk); #1;
      check("n3 out_valid", W'(bus3.out_valid), W'(1));
      check("n3 out_src", W'(bus3.out_src), W'(2));
      check("n3 out_data", bus3.out_data, word(2, 100));
      bus3.sel = 2'd3;
      #1;
      check("n3 in_ready sel3", W'(bus3.in_ready), W'(0));
      @(posedge clk); #1;
      check("n3 drained", W'(bus3.out_valid), W'(0));
      @(posedge clk); #1;
      check("n3 stays empty", W'(bus3.out_valid), W'(0));
      check("n3 data held", bus3.out_data, word(2, 100));
      bus3.in_valid = '0;

`ifdef MUXN_RR_EN
      step4(2'd0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, "rr_all0");
      step4(2'd0, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, "rr_all1");
      step4(2'd0, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, "rr_all2");
      step4(2'd0, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, "rr_all3");
      step4(2'd0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, "rr_all4");
      step4(2'd0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, "rr_idle");
`endif

      // Reset while a word is stalled: word dropped, pointer back to N-1.
      step4(2'd0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, "pre_rst_load");
      rst_n          = 1'b0;
      bus4.in_valid  = 4'b1111;
      bus4.out_ready = 1'b0;
      #1;
      check("mid_rst in_ready", W'(bus4.in_ready), W'(0));
      @(posedge clk); #1;
      check("mid_rst out_valid", W'(bus4.out_valid), W'(0));
      rst_n         = 1'b1;
      bus4.in_valid = '0;
      sb.delete();
      prev_vld = 1'b0;

`ifdef MUXN_RR_EN
      step4(2'd0, 4'b1101, 1'b1, 1'b1, 4'b0001, 1'b1, "rr_skip0");
      step4(2'd0, 4'b1101, 1'b1, 1'b1, 4'b0100, 1'b1, "rr_skip1");
      step4(2'd0, 4'b1101, 1'b1, 1'b1, 4'b1000, 1'b1, "rr_skip2");
      step4(2'd0, 4'b1101, 1'b1, 1'b1, 4'b0001, 1'b1, "rr_skip3");
      step4(2'd3, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, "rr_off_fixed");
`else
      step4(2'd2, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, "rr_mode_ignored0");
      step4(2'd1, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, "rr_mode_ignored1");
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
